// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared encodings and field indices for the MEM stage
package mem_access_stage_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    localparam int MEMREAD      = 2;
    localparam int MEMWRITE     = 1;
    localparam int MEM_MEMTOREG = 0;

    localparam int REGWRITE     = 1;
    localparam int WB_MEMTOREG  = 0;

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - wait-cycle counter with load-1/increment/clear and timeout compare
module mem_wait_counter #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load1,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_hit
);

    logic [TO_W-1:0] r_cnt;

    // Clear wins so an abort or completion never leaves a stale count behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load1) begin
            r_cnt <= TO_W'(1);
        end else if (i_inc) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

    assign o_hit = (r_cnt == TO_W'(TIMEOUT));

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: data-memory handshake, stall, MEM/WB register
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  WB_MEM,
    input  logic [2:0]  MEM_MEM,
    input  logic [4:0]  WN_MEM,
    input  logic [31:0] ALUOut_MEM,
    input  logic [31:0] RD2_WD_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [1:0]  WB_WB,
    output logic [31:0] RD_WB,
    output logic [31:0] ALUOut_WB,
    output logic [4:0]  WN_WB,
    output logic        align_err,
    output logic        bus_err
);

    logic        r_state;
    logic [1:0]  r_wb;
    logic [31:0] r_rd;
    logic [31:0] r_alu;
    logic [4:0]  r_wn;
    logic        r_align_err;
    logic        r_bus_err;

    logic w_access;
    logic w_aligned;
    logic w_load;
    logic w_hit;
    logic w_abort;
    logic w_load1;
    logic w_inc;
    logic w_clr;
    logic w_unused;

    assign w_access  = MEM_MEM[MEMREAD] | MEM_MEM[MEMWRITE];
    assign w_aligned = (ALUOut_MEM[1:0] == 2'b00);
    // Read+write together is a store, so only a pure read captures load data.
    assign w_load    = MEM_MEM[MEMREAD] & ~MEM_MEM[MEMWRITE];
    assign w_unused  = MEM_MEM[MEM_MEMTOREG];

    assign dmem_req   = w_access & w_aligned;
    assign dmem_we    = MEM_MEM[MEMWRITE];
    assign dmem_addr  = ALUOut_MEM;
    assign dmem_wdata = RD2_WD_MEM;

    assign w_abort = (r_state == ST_WAIT) & w_hit;
    assign stall   = dmem_req & ~dmem_ready & ~w_abort;

    assign w_load1 = (r_state == ST_IDLE) & dmem_req & ~dmem_ready;
    assign w_inc   = (r_state == ST_WAIT) & ~dmem_ready & ~w_hit;
    assign w_clr   = (r_state == ST_WAIT) & (dmem_ready | w_hit);

    mem_wait_counter #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wait_counter (
        .clk     (clk),
        .rst_n   (reset),
        .i_load1 (w_load1),
        .i_inc   (w_inc),
        .i_clr   (w_clr),
        .o_hit   (w_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_load1) r_state <= ST_WAIT;
                ST_WAIT: if (dmem_ready | w_hit) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Abort is checked first so a late ready on the final wait cycle is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb        <= '0;
            r_rd        <= '0;
            r_alu       <= '0;
            r_wn        <= '0;
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
            if (w_abort) begin
                r_wb      <= '0;
                r_bus_err <= 1'b1;
            end else if (w_access & ~w_aligned) begin
                r_wb        <= '0;
                r_align_err <= 1'b1;
            end else if (stall) begin
                r_wb <= '0;
            end else begin
                r_wb[REGWRITE]    <= WB_MEM[REGWRITE];
                r_wb[WB_MEMTOREG] <= WB_MEM[WB_MEMTOREG];
                r_wn              <= WN_MEM;
                r_alu             <= ALUOut_MEM;
                if (w_load) r_rd <= dmem_rdata;
            end
        end
    end

    assign WB_WB     = r_wb;
    assign RD_WB     = r_rd;
    assign ALUOut_WB = r_alu;
    assign WN_WB     = r_wn;
    assign align_err = r_align_err;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int TIMEOUT = 4;
    localparam int K_PASS   = 0;
    localparam int K_BUBBLE = 1;
    localparam int K_ALIGN  = 2;
    localparam int K_ABORT  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  WB_MEM;
    logic [2:0]  MEM_MEM;
    logic [4:0]  WN_MEM;
    logic [31:0] ALUOut_MEM;
    logic [31:0] RD2_WD_MEM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [1:0]  WB_WB;
    logic [31:0] RD_WB;
    logic [31:0] ALUOut_WB;
    logic [4:0]  WN_WB;
    logic        align_err;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .WB_MEM     (WB_MEM),
        .MEM_MEM    (MEM_MEM),
        .WN_MEM     (WN_MEM),
        .ALUOut_MEM (ALUOut_MEM),
        .RD2_WD_MEM (RD2_WD_MEM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .stall      (stall),
        .WB_WB      (WB_WB),
        .RD_WB      (RD_WB),
        .ALUOut_WB  (ALUOut_WB),
        .WN_WB      (WN_WB),
        .align_err  (align_err),
        .bus_err    (bus_err)
    );

    typedef struct {
        logic [2:0]  mem;
        logic [1:0]  wb;
        logic [4:0]  wn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ready;
        logic [31:0] rdata;
        logic        exp_req;
        logic        exp_we;
        logic        exp_stall;
        int          kind;
    } vec_t;

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wn;
        logic        ae;
        logic        be;
    } mwb_t;

    mwb_t m;
    mwb_t sbq[$];
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] mem, input logic [1:0] wb, input logic [4:0] wn,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic ready,
                                input logic [31:0] rdata, input logic er, input logic ew,
                                input logic es, input int kind);
        vec_t v;
        v.mem = mem; v.wb = wb; v.wn = wn; v.addr = addr; v.wdata = wdata;
        v.ready = ready; v.rdata = rdata; v.exp_req = er; v.exp_we = ew;
        v.exp_stall = es; v.kind = kind;
        return v;
    endfunction

    task automatic step(input vec_t v);
        mwb_t e;
        mwb_t got;
        MEM_MEM    = v.mem;
        WB_MEM     = v.wb;
        WN_MEM     = v.wn;
        ALUOut_MEM = v.addr;
        RD2_WD_MEM = v.wdata;
        dmem_ready = v.ready;
        dmem_rdata = v.rdata;
        #1;
        chk("dmem_req", 32'(dmem_req), 32'(v.exp_req));
        chk("dmem_we", 32'(dmem_we), 32'(v.exp_we));
        chk("stall", 32'(stall), 32'(v.exp_stall));
        chk("dmem_addr", dmem_addr, v.addr);
        chk("dmem_wdata", dmem_wdata, v.wdata);
        e = m;
        e.ae = 1'b0;
        e.be = 1'b0;
        case (v.kind)
            K_PASS: begin
                e.wb  = v.wb;
                e.wn  = v.wn;
                e.alu = v.addr;
                if (v.mem == 3'b100 || v.mem == 3'b101) e.rd = v.rdata;
            end
            K_BUBBLE: e.wb = 2'b00;
            K_ALIGN: begin e.wb = 2'b00; e.ae = 1'b1; end
            default: begin e.wb = 2'b00; e.be = 1'b1; end
        endcase
        m = e;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = sbq.pop_front();
            chk("WB_WB", 32'(WB_WB), 32'(got.wb));
            chk("RD_WB", RD_WB, got.rd);
            chk("ALUOut_WB", ALUOut_WB, got.alu);
            chk("WN_WB", 32'(WN_WB), 32'(got.wn));
            chk("align_err", 32'(align_err), 32'(got.ae));
            chk("bus_err", 32'(bus_err), 32'(got.be));
        end
    endtask

    task automatic chk_regs_zero(input string tag);
        chk({tag, "_WB_WB"}, 32'(WB_WB), 32'd0);
        chk({tag, "_RD_WB"}, RD_WB, 32'd0);
        chk({tag, "_ALUOut_WB"}, ALUOut_WB, 32'd0);
        chk({tag, "_WN_WB"}, 32'(WN_WB), 32'd0);
        chk({tag, "_align_err"}, 32'(align_err), 32'd0);
        chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    endtask

    task automatic drive_idle();
        MEM_MEM = '0; WB_MEM = '0; WN_MEM = '0; ALUOut_MEM = '0;
        RD2_WD_MEM = '0; dmem_ready = 1'b0; dmem_rdata = '0;
    endtask

    initial begin
        tbl[0] = mk(3'b101, 2'b11, 5'd5,  32'h10, 32'h0,  1'b1, 32'hDEADBEEF, 1, 0, 0, K_PASS);
        tbl[1] = mk(3'b000, 2'b10, 5'd7,  32'h55, 32'h0,  1'b0, 32'h0000AAAA, 0, 0, 0, K_PASS);
        tbl[2] = mk(3'b101, 2'b11, 5'd9,  32'h13, 32'h0,  1'b0, 32'h11111111, 0, 0, 0, K_ALIGN);
        tbl[3] = mk(3'b010, 2'b00, 5'd3,  32'h40, 32'h77, 1'b1, 32'h22222222, 1, 1, 0, K_PASS);
        tbl[4] = mk(3'b010, 2'b00, 5'd4,  32'h22, 32'h66, 1'b1, 32'h33333333, 0, 1, 0, K_ALIGN);
        tbl[5] = mk(3'b111, 2'b01, 5'd6,  32'h44, 32'h99, 1'b1, 32'h44444444, 1, 1, 0, K_PASS);
        tbl[6] = mk(3'b101, 2'b11, 5'd8,  32'h80, 32'h0,  1'b1, 32'h12345678, 1, 0, 0, K_PASS);
        tbl[7] = mk(3'b000, 2'b10, 5'd10, 32'h01, 32'h0,  1'b0, 32'h55555555, 0, 0, 0, K_PASS);

        reset = 1'b0;
        drive_idle();
        m = '{default: '0};
        #1;
        chk_regs_zero("reset");
        chk("reset_stall", 32'(stall), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 8; i++) step(tbl[i]);

        // 3-wait store: three stall bubbles, completion on the 4th cycle
        for (int i = 0; i < 3; i++)
            step(mk(3'b010, 2'b10, 5'd12, 32'h20, 32'h1234, 1'b0, 32'h0, 1, 1, 1, K_BUBBLE));
        step(mk(3'b010, 2'b10, 5'd12, 32'h20, 32'h1234, 1'b1, 32'h0, 1, 1, 0, K_PASS));

        // timeout with ready never asserted
        for (int i = 0; i < TIMEOUT; i++)
            step(mk(3'b101, 2'b11, 5'd13, 32'h30, 32'h0, 1'b0, 32'h0, 1, 0, 1, K_BUBBLE));
        step(mk(3'b101, 2'b11, 5'd13, 32'h30, 32'h0, 1'b0, 32'h0, 1, 0, 0, K_ABORT));
        chk("state_after_abort", 32'(dut.r_state), 32'(ST_IDLE));

        // timeout where ready arrives on the abort cycle: it must be ignored
        for (int i = 0; i < TIMEOUT; i++)
            step(mk(3'b101, 2'b11, 5'd14, 32'h34, 32'h0, 1'b0, 32'h0, 1, 0, 1, K_BUBBLE));
        step(mk(3'b101, 2'b11, 5'd14, 32'h34, 32'h0, 1'b1, 32'hBADBAD00, 1, 0, 0, K_ABORT));
        chk("state_after_late_ready", 32'(dut.r_state), 32'(ST_IDLE));

        // reset mid-WAIT after two wait cycles, asserted between clock edges
        for (int i = 0; i < 2; i++)
            step(mk(3'b101, 2'b11, 5'd15, 32'h50, 32'h0, 1'b0, 32'h0, 1, 0, 1, K_BUBBLE));
        #2;
        reset = 1'b0;
        drive_idle();
        #1;
        chk_regs_zero("midreset");
        chk("midreset_req", 32'(dmem_req), 32'd0);
        chk("midreset_stall", 32'(stall), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m = '{default: '0};
        sbq.delete();
        step(mk(3'b101, 2'b11, 5'd16, 32'h60, 32'h0, 1'b1, 32'hCAFEF00D, 1, 0, 0, K_PASS));
        step(mk(3'b000, 2'b10, 5'd17, 32'h55, 32'h0, 1'b0, 32'h0, 0, 0, 0, K_PASS));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
